// File: rtl/uart_tx.sv
// UART transmitter: serialises one DATA_BITS word per request, LSB first, with
// start/stop framing timed off a shared OVERSAMPLE x baud tick.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx_done,
    output logic                 o_tx
);

    localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] sh_next;

    assign sh_next = sh_q >> 1;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // A tick coinciding with acceptance is deliberately not counted.
                if (i_tx_start) begin
                    sh_d    = i_tx_data;
                    tick_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (i_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                        tx_d    = sh_q[0];
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end else begin
                            sh_d  = sh_next;
                            bit_d = bit_q + BW'(1);
                            tx_d  = sh_next[0];
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                tx_d = 1'b1;
                if (i_tick) begin
                    if (tick_q == SB_LAST) begin
                        tick_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
        endcase
    end

    // The line is a flop preset high, so an abort drives it straight to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_done = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: tick-count frame model checked every cycle, a loopback
// receiver, and directed plus randomized scenarios.
module tb_uart_tx;

    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int SB    = 16;
    localparam int FRAME = OS * (1 + DB) + SB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_tick = 1'b0;
    logic          i_tx_start = 1'b0;
    logic [DB-1:0] i_tx_data = '0;
    logic          o_tx_done, o_tx;

    int pass_cnt = 0;
    int total_cnt = 0;

    uart_tx #(.DATA_BITS(DB), .SB_TICK(SB), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_tx_start(i_tx_start),
        .i_tx_data(i_tx_data), .o_tx_done(o_tx_done), .o_tx(o_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Tick every 4 clk, gated for the stall scenario.
    logic tick_en = 1'b1;
    int   tphase = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tphase++;
            i_tick = tick_en && (tphase % 4 == 0);
        end
    end

    // Model: a frame is just "ticks elapsed since acceptance".
    logic          m_busy = 1'b0;
    int            m_k = 0;
    logic [DB-1:0] m_byte = '0;
    logic [DB-1:0] m_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_k    <= 0;
        end else if (!m_busy) begin
            if (i_tx_start) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_byte <= i_tx_data;
                m_q.push_back(i_tx_data);
            end
        end else if (i_tick) begin
            if (m_k + 1 == FRAME) m_busy <= 1'b0;
            m_k <= m_k + 1;
        end
    end

    function automatic logic exp_tx();
        if (!m_busy)                exp_tx = 1'b1;
        else if (m_k < OS)          exp_tx = 1'b0;
        else if (m_k < OS * (1+DB)) exp_tx = m_byte[(m_k - OS) / OS];
        else                        exp_tx = 1'b1;
    endfunction

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("line", int'(o_tx), int'(exp_tx()));
            chk("done", int'(o_tx_done), int'(!m_busy));
        end
    end

    // Loopback receiver sampling mid-bit by tick count.
    logic          rx_busy = 1'b0;
    int            rx_cnt = 0;
    logic [DB-1:0] rx_sh = '0;
    logic [DB-1:0] rx_q[$];
    int            rx_ferr = 0;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
        end else if (!rx_busy) begin
            if (!o_tx) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 0;
            end
        end else if (i_tick) begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= OS + OS/2 && rx_cnt < OS * (1+DB) && (rx_cnt - OS/2) % OS == 0)
                rx_sh[(rx_cnt - OS - OS/2) / OS] <= o_tx;
            if (rx_cnt == OS * (1+DB) + SB/2) begin
                rx_busy <= 1'b0;
                if (o_tx) rx_q.push_back(rx_sh);
                else rx_ferr <= rx_ferr + 1;
            end
        end
    end

    int   done_falls = 0;
    int   tx_toggles = 0;
    logic prev_done = 1'b1, prev_tx = 1'b1;
    always @(negedge clk) begin
        if (prev_done && !o_tx_done) done_falls <= done_falls + 1;
        if (prev_tx != o_tx) tx_toggles <= tx_toggles + 1;
        prev_done <= o_tx_done;
        prev_tx   <= o_tx;
    end

    task automatic wait_done(input logic v, input int max, input string nm);
        int n = 0;
        while (o_tx_done !== v && n < max) begin
            @(negedge clk);
            n++;
        end
        if (o_tx_done !== v) chk({nm, "_timeout"}, int'(o_tx_done), int'(v));
    endtask

    task automatic send(input logic [DB-1:0] d);
        @(posedge clk);
        #1;
        i_tx_start = 1'b1;
        i_tx_data  = d;
        @(posedge clk);
        #1;
        i_tx_start = 1'b0;
    endtask

    task automatic chk_rx(input string nm, input logic [DB-1:0] e0, input logic [DB-1:0] e1, input int n);
        chk({nm, "_count"}, rx_q.size(), n);
        if (n > 0 && rx_q.size() > 0) chk({nm, "_b0"}, int'(rx_q[0]), int'(e0));
        if (n > 1 && rx_q.size() > 1) chk({nm, "_b1"}, int'(rx_q[1]), int'(e1));
    endtask

    initial begin
        logic [9:0] seq;
        int c, tk, rise_c;
        int hi;
        int bad;

        // Reset held for 5 cycles with ticks running.
        @(negedge clk);
        cmp_en = 1'b1;
        tx_toggles = 0;
        repeat (5) @(negedge clk);
        chk("reset_tx", int'(o_tx), 1);
        chk("reset_done", int'(o_tx_done), 1);
        chk("reset_toggles", tx_toggles, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Single byte A5 with literal line levels and timing.
        rx_q.delete();
        seq = 10'b11_0100_1010;   // stop, A5 msb..lsb, start (read lsb first)
        @(posedge clk);
        #1;
        i_tx_start = 1'b1;
        i_tx_data  = 8'hA5;
        @(posedge clk);
        #1;
        i_tx_start = 1'b0;
        tk = 0;
        rise_c = -1;
        for (c = 1; c <= 700 && rise_c < 0; c++) begin
            @(negedge clk);
            if (c == 1) chk("a5_done_fall", int'(o_tx_done), 0);
            if (o_tx_done) rise_c = c - 1;
            else begin
                if (i_tick) tk++;
                if (c % 64 == 32 && c / 64 < 10) chk($sformatf("a5_bit%0d", c / 64), int'(o_tx), int'(seq[c / 64]));
            end
        end
        chk("a5_ticks", tk, FRAME);
        chk("a5_cycles_ok", int'(rise_c >= 637 && rise_c <= 640), 1);
        repeat (20) @(negedge clk);
        chk_rx("a5_rx", 8'hA5, 8'h00, 1);

        // Start while busy is ignored.
        rx_q.delete();
        done_falls = 0;
        send(8'h3C);
        repeat (200) @(negedge clk);
        send(8'hFF);
        wait_done(1'b1, 1000, "busy");
        repeat (300) @(negedge clk);
        chk("busy_done", int'(o_tx_done), 1);
        chk("busy_frames", done_falls, 1);
        chk_rx("busy_rx", 8'h3C, 8'h00, 1);

        // Back-to-back frames with start held high.
        rx_q.delete();
        @(posedge clk);
        #1;
        i_tx_start = 1'b1;
        i_tx_data  = 8'h00;
        wait_done(1'b0, 20, "b2b_acc0");
        i_tx_data = 8'hFF;
        wait_done(1'b1, 1000, "b2b_end0");
        hi = 0;
        while (o_tx_done && hi < 10) begin
            @(negedge clk);
            hi++;
        end
        chk("b2b_gap", hi, 1);
        #2;
        i_tx_start = 1'b0;
        wait_done(1'b1, 1000, "b2b_end1");
        repeat (20) @(negedge clk);
        chk_rx("b2b_rx", 8'h00, 8'hFF, 2);

        // Asynchronous reset during data bit 3 of 55.
        rx_q.delete();
        send(8'h55);
        repeat (64 * 4 + 32) @(negedge clk);
        chk("rst_pre_tx", int'(o_tx), 0);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_async_tx", int'(o_tx), 1);
        chk("rst_async_done", int'(o_tx_done), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h81);
        wait_done(1'b1, 1000, "rst_81");
        repeat (20) @(negedge clk);
        chk_rx("rst_rx", 8'h81, 8'h00, 1);

        // Tick stall in START.
        rx_q.delete();
        send(8'hC3);
        repeat (10) @(negedge clk);
        tick_en = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (o_tx !== 1'b0 || o_tx_done !== 1'b0) bad++;
        end
        chk("stall_held", bad, 0);
        tick_en = 1'b1;
        wait_done(1'b1, 1200, "stall");
        repeat (20) @(negedge clk);
        chk_rx("stall_rx", 8'hC3, 8'h00, 1);

        // Randomized requests, including ones that land while busy.
        rx_q.delete();
        m_q.delete();
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 300)) @(posedge clk);
            #1;
            i_tx_start = 1'b1;
            i_tx_data  = DB'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            i_tx_start = 1'b0;
        end
        wait_done(1'b1, 1000, "rand");
        repeat (20) @(negedge clk);
        chk("rand_count", rx_q.size(), m_q.size());
        for (int i = 0; i < m_q.size() && i < rx_q.size(); i++)
            chk($sformatf("rand_byte%0d", i), int'(rx_q[i]), int'(m_q[i]));
        chk("rx_framing", rx_ferr, 0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter that consumes the byte stream the debug FSM produces (o_tx_start / o_tx_data) and drives the board TX pin.
- Reports readiness back to the debug FSM on o_tx_done.
- Uses the shared 16x-oversampling baud tick, the same one the UART receiver uses, so both sides run at an identical bit rate.
- Frame format: 8N1 by default (1 start bit, DATA_BITS data bits LSB first, stop bit(s), no parity).

Parameters:
- DATA_BITS, 8 (`UART_BITS): data bits per frame.
- SB_TICK, 16: i_tick pulses per stop period; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- OVERSAMPLE, 16: i_tick pulses per start/data bit.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_tick  input  1  baud tick, 1-cycle pulse at OVERSAMPLE x baud rate.
- i_tx_start  input  1  request to send i_tx_data; sampled only while idle.
- i_tx_data  input  DATA_BITS  byte to send; latched on the accepting cycle.
- o_tx_done  output  1  high = idle and ready to accept; low while a frame is in flight.
- o_tx  output  1  serial line; idle high.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; o_tx=1; o_tx_done=1.
  - Tick counter, bit counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high with no glitch to 0.
- State IDLE:
  - o_tx=1, o_tx_done=1.
  - If i_tx_start=1 on a rising edge: latch i_tx_data into the shift register, clear the tick counter, go to START.
  - o_tx=0 and o_tx_done=0 take effect from that same edge, i.e. one cycle of latency from the start pulse.
- State START:
  - o_tx=0.
  - Count i_tick; when OVERSAMPLE ticks are seen (counter = OVERSAMPLE-1 with i_tick=1), clear the tick counter and bit counter, go to DATA.
- State DATA:
  - o_tx = shift register bit 0.
  - After OVERSAMPLE ticks, shift right by 1 and increment the bit counter.
  - When the bit counter = DATA_BITS-1 at the end of the bit, go to STOP instead of shifting again.
- State STOP:
  - o_tx=1.
  - After SB_TICK ticks, go to IDLE; o_tx_done rises on that edge.
- i_tick handling:
  - All counters advance only on cycles with i_tick=1.
  - Without ticks the FSM holds its state and output indefinitely.
- Start handling:
  - i_tx_start while busy is ignored, not queued. The caller must wait for o_tx_done=1.
  - i_tx_start held high continuously produces back-to-back frames: a new frame is accepted on the first IDLE cycle after STOP.
  - Only one idle cycle is inserted between frames, so the stop bit is followed immediately by the next start bit.
- Data latching: changes on i_tx_data after the accepting edge do not affect the frame in flight.
- Counter widths: tick counter is $clog2(max(OVERSAMPLE,SB_TICK)) bits; bit counter is $clog2(DATA_BITS) bits. Neither wraps outside its state; both are cleared on state entry.
- Frame duration: exactly (OVERSAMPLE*(1+DATA_BITS) + SB_TICK) ticks from the accepting edge to o_tx_done=1, plus the sub-tick alignment of the first tick.
- Simultaneous i_tick and i_tx_start in IDLE: the start is accepted; that tick is not counted toward the start bit.

Test Plan:
- Reset: hold rst=0 for 5 cycles, with i_tick every 4 clk throughout the bench -> o_tx=1, o_tx_done=1; no transitions on o_tx.
- Single byte: pulse i_tx_start=1 for 1 cycle with i_tx_data=8'hA5 ->
  - o_tx_done falls the next cycle.
  - o_tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 ticks = 64 clk.
  - o_tx_done rises 640 clk after acceptance.
- Busy ignore: start 8'h3C, then pulse i_tx_start with 8'hFF mid-DATA -> the serialized byte is 8'h3C only; exactly one frame; o_tx_done=1 afterwards with no second frame.
- Back-to-back: hold i_tx_start=1 with 8'h00 then 8'hFF -> two frames separated by exactly 1 idle cycle; the loopback receiver decodes 8'h00, 8'hFF.
- Reset mid-frame: assert rst=0 during data bit 3 of 8'h55 -> o_tx=1 and o_tx_done=1 immediately (asynchronous). After release, a new frame of 8'h81 transmits correctly.
- Tick stall: stop i_tick for 200 clk during START -> o_tx stays 0 and state is held. Resuming ticks completes a correct frame of 16 ticks per bit.
